// File: rtl/mem_bus_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arb_pkg
// Description : Shared types and default constants for the two-master
//               memory bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_bus_arb_pkg;

    localparam int          c_DEFAULT_TIMEOUT_CYCLES = 1024;
    localparam logic [31:0] c_DEFAULT_ERR_DATA       = 32'hFFFF_FFFF;

    // Arbiter FSM states, explicit 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // One latched master request, as forwarded to the slave bus
    typedef struct packed {
        logic [31:0] data;
        logic [31:0] address;
        logic [2:0]  bhw;
        logic        write_notread;
    } bus_req_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Combinational two-way round-robin pick. A lone requester
//               wins; on a tie the master not granted last time wins.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
    input  logic [1:0] i_pending,
    input  logic       i_last_grant,
    output logic       o_grant_valid,
    output logic       o_grant_id
);

    // Winner selection: tie goes to the opposite of the previous grant
    always_comb begin
        o_grant_valid = |i_pending;
        o_grant_id    = 1'b0;
        if (&i_pending) begin
            o_grant_id = ~i_last_grant;
        end else begin
            o_grant_id = i_pending[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Two-master round-robin arbiter in front of memory_top.
//               Latches one request per master, issues one slave
//               transaction at a time, routes the response back and turns
//               a silent slave into an error response after a timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
    import mem_bus_arb_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = c_DEFAULT_TIMEOUT_CYCLES,
    parameter logic [31:0] ERR_DATA       = c_DEFAULT_ERR_DATA
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    // master 0 (CPU)
    input  logic [31:0] i_m0_bus_data,
    input  logic [31:0] i_m0_bus_address,
    input  logic        i_m0_bus_DV,
    input  logic [2:0]  i_m0_bhw,
    input  logic        i_m0_write_notread,
    output logic [31:0] o_m0_bus_data,
    output logic        o_m0_bus_DV,
    output logic        o_m0_err,
    output logic        o_m0_overrun,
    // master 1 (DMA / loader)
    input  logic [31:0] i_m1_bus_data,
    input  logic [31:0] i_m1_bus_address,
    input  logic        i_m1_bus_DV,
    input  logic [2:0]  i_m1_bhw,
    input  logic        i_m1_write_notread,
    output logic [31:0] o_m1_bus_data,
    output logic        o_m1_bus_DV,
    output logic        o_m1_err,
    output logic        o_m1_overrun,
    // slave side (memory_top)
    output logic [31:0] o_bus_data,
    output logic [31:0] o_bus_address,
    output logic        o_bus_DV,
    output logic [2:0]  o_bhw,
    output logic        o_write_notread,
    input  logic [31:0] i_bus_data,
    input  logic        i_bus_DV
);

    localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_last_grant;
    logic               r_cur_id;
    logic               r_bus_dv;
    bus_req_t           r_bus_req;

    logic               w_grant_valid;
    logic               w_grant_id;
    logic               w_issue;
    logic               w_rsp_fire;
    logic               w_rsp_timeout;

    logic [1:0]         w_req_dv;
    bus_req_t           w_req_in   [2];
    bus_req_t           w_hold     [2];
    logic [1:0]         w_pending;
    logic [1:0]         w_overrun;
    logic [1:0]         w_rsp_dv;
    logic [1:0]         w_rsp_err;
    logic [31:0]        w_rsp_data [2];

    assign w_req_dv    = {i_m1_bus_DV, i_m0_bus_DV};
    assign w_req_in[0] = {i_m0_bus_data, i_m0_bus_address, i_m0_bhw, i_m0_write_notread};
    assign w_req_in[1] = {i_m1_bus_data, i_m1_bus_address, i_m1_bhw, i_m1_write_notread};

    rr_arbiter2 u_rr_arbiter2 (
        .i_pending     (w_pending),
        .i_last_grant  (r_last_grant),
        .o_grant_valid (w_grant_valid),
        .o_grant_id    (w_grant_id)
    );

    // Per-master request latch, overrun flag and response registers
    generate
        for (genvar i = 0; i < 2; i++) begin : g_master
            localparam logic c_ID = 1'(i);

            bus_req_t    r_hold;
            logic        r_pending;
            logic        r_overrun;
            logic        r_rsp_dv;
            logic        r_rsp_err;
            logic [31:0] r_rsp_data;
            logic        w_mine;

            // Response events are only routed to the master currently granted
            assign w_mine = w_rsp_fire && (r_cur_id == c_ID);

            // Capture a strobe into an empty slot; a strobe into a full slot is dropped and flagged
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    r_hold    <= '0;
                    r_pending <= 1'b0;
                    r_overrun <= 1'b0;
                end else begin
                    if (w_req_dv[i]) begin
                        if (!r_pending) begin
                            r_hold    <= w_req_in[i];
                            r_pending <= 1'b1;
                        end else begin
                            r_overrun <= 1'b1;
                        end
                    end
                    if (w_mine) begin
                        r_pending <= 1'b0;
                    end
                end
            end

            // Register the response one cycle after the slave answers (or times out)
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    r_rsp_dv   <= 1'b0;
                    r_rsp_err  <= 1'b0;
                    r_rsp_data <= '0;
                end else begin
                    r_rsp_dv  <= w_mine;
                    r_rsp_err <= w_mine && w_rsp_timeout;
                    if (w_mine) begin
                        r_rsp_data <= w_rsp_timeout ? ERR_DATA : i_bus_data;
                    end
                end
            end

            assign w_hold[i]     = r_hold;
            assign w_pending[i]  = r_pending;
            assign w_overrun[i]  = r_overrun;
            assign w_rsp_dv[i]   = r_rsp_dv;
            assign w_rsp_err[i]  = r_rsp_err;
            assign w_rsp_data[i] = r_rsp_data;
        end
    endgenerate

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state plus issue / response / timeout decode
    always_comb begin
        w_state_nxt   = r_state;
        w_issue       = 1'b0;
        w_rsp_fire    = 1'b0;
        w_rsp_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_valid) begin
                    w_issue     = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
                if (i_bus_DV) begin
                    w_rsp_fire  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (i_bus_DV) begin
                    w_rsp_fire  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_rsp_fire    = 1'b1;
                    w_rsp_timeout = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Timeout counter: cleared on issue, counts while waiting for the slave
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (r_state == ST_ISSUE) begin
            r_cnt <= '0;
        end else if (r_state == ST_WAIT) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    // Slave-side request registers, issue strobe and round-robin history
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_bus_req    <= '0;
            r_bus_dv     <= 1'b0;
            r_cur_id     <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_bus_dv <= w_issue;
            if (w_issue) begin
                r_bus_req <= w_hold[w_grant_id];
                r_cur_id  <= w_grant_id;
            end
            if (w_rsp_fire) begin
                r_last_grant <= r_cur_id;
            end
        end
    end

    assign o_bus_data      = r_bus_req.data;
    assign o_bus_address   = r_bus_req.address;
    assign o_bhw           = r_bus_req.bhw;
    assign o_write_notread = r_bus_req.write_notread;
    assign o_bus_DV        = r_bus_dv;

    assign o_m0_bus_data = w_rsp_data[0];
    assign o_m0_bus_DV   = w_rsp_dv[0];
    assign o_m0_err      = w_rsp_err[0];
    assign o_m0_overrun  = w_overrun[0];
    assign o_m1_bus_data = w_rsp_data[1];
    assign o_m1_bus_DV   = w_rsp_dv[1];
    assign o_m1_err      = w_rsp_err[1];
    assign o_m1_overrun  = w_overrun[1];

endmodule
`default_nettype wire
